// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the combinational ALU, with a valid/ready handshake.
// Optional ID_EX_FWD_EN adds MEM/WB operand forwarding and refreshes held operands during stalls.
module id_ex_stage #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  input  logic [AW-1:0]        rs_addr,
  input  logic [AW-1:0]        rt_addr,
  input  logic [DW-1:0]        rs_data,
  input  logic [DW-1:0]        rt_data,
  input  logic [AW-1:0]        rd_addr,
  input  logic                 wr_en,
  input  logic [15:0]          imm16,
  input  logic                 use_imm,
  input  logic                 imm_zext,
  input  logic [3:0]           alu_op,
  input  logic                 fwd_mem_en,
  input  logic                 fwd_wb_en,
  input  logic [AW-1:0]        fwd_mem_addr,
  input  logic [AW-1:0]        fwd_wb_addr,
  input  logic [DW-1:0]        fwd_mem_data,
  input  logic [DW-1:0]        fwd_wb_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] opa,
  output logic signed [DW-1:0] opb,
  output logic [3:0]           op,
  output logic [AW-1:0]        rd_addr_q,
  output logic                 wr_en_q
);

  localparam logic [3:0] ALU_MVHI = 4'd11;

  logic          valid_q;
  logic [DW-1:0] a_q, b_q;
  logic [3:0]    op_q;
  logic [AW-1:0] rd_q, rs_q, rt_q;
  logic          wr_q, imm_q;

  logic          cap, hold;
  logic [DW-1:0] imm_ext, b_in, fwd_a, fwd_b;

  assign in_ready = !valid_q || out_ready;
  assign cap      = in_valid && in_ready && !flush;
  assign hold     = valid_q && !out_ready;

  // MVHI places the raw immediate in the upper half downstream, so it must not be sign-extended
  assign imm_ext = (imm_zext || alu_op == ALU_MVHI) ? {{(DW-16){1'b0}}, imm16}
                                                    : {{(DW-16){imm16[15]}}, imm16};
  assign b_in    = use_imm ? imm_ext : rt_data;

`ifdef ID_EX_FWD_EN
  always_comb begin
    fwd_a = a_q;
    if (valid_q && rs_q != '0) begin
      if (fwd_mem_en && fwd_mem_addr == rs_q) begin
        fwd_a = fwd_mem_data;
      end else if (fwd_wb_en && fwd_wb_addr == rs_q) begin
        fwd_a = fwd_wb_data;
      end
    end
  end

  always_comb begin
    fwd_b = b_q;
    if (valid_q && !imm_q && rt_q != '0) begin
      if (fwd_mem_en && fwd_mem_addr == rt_q) begin
        fwd_b = fwd_mem_data;
      end else if (fwd_wb_en && fwd_wb_addr == rt_q) begin
        fwd_b = fwd_wb_data;
      end
    end
  end
`else
  assign fwd_a = a_q;
  assign fwd_b = b_q;

  logic unused_fwd;
  assign unused_fwd = ^{fwd_mem_en, fwd_wb_en, fwd_mem_addr, fwd_wb_addr, fwd_mem_data,
                        fwd_wb_data, rs_q, rt_q, imm_q, hold};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      wr_q    <= 1'b0;
      imm_q   <= 1'b0;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (cap) begin
        valid_q <= 1'b1;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end

      if (cap) begin
        a_q   <= rs_data;
        b_q   <= b_in;
        op_q  <= alu_op;
        rd_q  <= rd_addr;
        rs_q  <= rs_addr;
        rt_q  <= rt_addr;
        wr_q  <= wr_en;
        imm_q <= use_imm;
`ifdef ID_EX_FWD_EN
      end else if (hold) begin
        // Latch forwarded values so a producer retiring mid-stall is not lost
        a_q <= fwd_a;
        b_q <= fwd_b;
`endif
      end
    end
  end

  assign out_valid = valid_q;
  assign opa       = fwd_a;
  assign opb       = fwd_b;
  assign op        = op_q;
  assign rd_addr_q = rd_q;
  assign wr_en_q   = wr_q && valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, hand-written hazard/flush/reset
// sequences, then randomized traffic against a behavioural model of the stage.
module tb_id_ex_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_MVHI = 4'd11;
`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, flush;
  logic [AW-1:0] rs_addr, rt_addr, rd_addr;
  logic [DW-1:0] rs_data, rt_data;
  logic wr_en, use_imm, imm_zext;
  logic [15:0] imm16;
  logic [3:0] alu_op;
  logic fwd_mem_en, fwd_wb_en;
  logic [AW-1:0] fwd_mem_addr, fwd_wb_addr;
  logic [DW-1:0] fwd_mem_data, fwd_wb_data;
  logic out_valid, out_ready;
  logic signed [DW-1:0] opa, opb;
  logic [3:0] op;
  logic [AW-1:0] rd_addr_q;
  logic wr_en_q;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .rd_addr(rd_addr), .wr_en(wr_en), .imm16(imm16), .use_imm(use_imm), .imm_zext(imm_zext),
    .alu_op(alu_op), .fwd_mem_en(fwd_mem_en), .fwd_wb_en(fwd_wb_en),
    .fwd_mem_addr(fwd_mem_addr), .fwd_wb_addr(fwd_wb_addr), .fwd_mem_data(fwd_mem_data),
    .fwd_wb_data(fwd_wb_data), .out_valid(out_valid), .out_ready(out_ready), .opa(opa),
    .opb(opb), .op(op), .rd_addr_q(rd_addr_q), .wr_en_q(wr_en_q)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    in_valid = 0; flush = 0; rs_addr = 0; rt_addr = 0; rs_data = 0; rt_data = 0;
    rd_addr = 0; wr_en = 0; imm16 = 0; use_imm = 0; imm_zext = 0; alu_op = ALU_ADD;
    fwd_mem_en = 0; fwd_wb_en = 0; fwd_mem_addr = 0; fwd_wb_addr = 0;
    fwd_mem_data = 0; fwd_wb_data = 0;
  endtask

  typedef struct {
    logic [31:0] rs_d, rt_d;
    logic [15:0] imm;
    logic        ui, zx;
    logic [3:0]  aop;
    logic [31:0] e_opa, e_opb;
  } vec_t;
  vec_t vecs[8];

  // Behavioural model state
  logic        mv;
  logic [31:0] ma, mb;
  logic [3:0]  mop;
  logic [4:0]  mrd, mrs, mrt;
  logic        mwr, mimm;

  function automatic logic [31:0] fwdv(input logic [4:0] a, input logic [31:0] held);
    if (!FWD || !mv || a == 0) return held;
    if (fwd_mem_en && fwd_mem_addr == a) return fwd_mem_data;
    if (fwd_wb_en && fwd_wb_addr == a) return fwd_wb_data;
    return held;
  endfunction

  initial begin
    logic [31:0] eo_a, eo_b, ext;
    logic        capm;

    vecs[0] = '{32'd5, 32'd7, 16'h0000, 1'b0, 1'b0, ALU_ADD, 32'd5, 32'd7};
    vecs[1] = '{32'd1, 32'd2, 16'h8000, 1'b1, 1'b0, ALU_ADD, 32'd1, 32'hFFFF8000};
    vecs[2] = '{32'd1, 32'd2, 16'h8000, 1'b1, 1'b1, ALU_ADD, 32'd1, 32'h00008000};
    vecs[3] = '{32'd3, 32'd4, 16'h1234, 1'b1, 1'b0, ALU_MVHI, 32'd3, 32'h00001234};
    vecs[4] = '{32'd3, 32'd4, 16'h8000, 1'b1, 1'b0, ALU_MVHI, 32'd3, 32'h00008000};
    vecs[5] = '{32'd6, 32'd4, 16'h7FFF, 1'b1, 1'b0, ALU_SUB, 32'd6, 32'h00007FFF};
    vecs[6] = '{32'd6, 32'd9, 16'hFFFF, 1'b1, 1'b0, ALU_SUB, 32'd6, 32'hFFFFFFFF};
    vecs[7] = '{32'hDEADBEEF, 32'hCAFEF00D, 16'h8000, 1'b0, 1'b0, ALU_SUB,
                32'hDEADBEEF, 32'hCAFEF00D};

    idle();
    out_ready = 0;
    rst_n = 0;
    #3;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_opa", opa, 32'd0);
    chk("rst_opb", opb, 32'd0);
    chk("rst_op", {28'b0, op}, 32'd0);
    chk("rst_rd", {27'b0, rd_addr_q}, 32'd0);
    chk("rst_wr_en_q", {31'b0, wr_en_q}, 32'd0);
    @(negedge clk);
    rst_n = 1;

    // Vector table: capture, check one cycle later, then check the bubble
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      idle();
      in_valid = 1; rs_addr = 1; rt_addr = 2; rd_addr = 7; wr_en = 1; out_ready = 1;
      rs_data = vecs[i].rs_d; rt_data = vecs[i].rt_d; imm16 = vecs[i].imm;
      use_imm = vecs[i].ui; imm_zext = vecs[i].zx; alu_op = vecs[i].aop;
      @(negedge clk);
      idle();
      #1;
      chk($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_opa", i), opa, vecs[i].e_opa);
      chk($sformatf("vec%0d_opb", i), opb, vecs[i].e_opb);
      chk($sformatf("vec%0d_op", i), {28'b0, op}, {28'b0, vecs[i].aop});
      chk($sformatf("vec%0d_rd", i), {27'b0, rd_addr_q}, 32'd7);
      chk($sformatf("vec%0d_wr", i), {31'b0, wr_en_q}, 32'd1);
      @(negedge clk);
      #1;
      chk($sformatf("vec%0d_bubble", i), {31'b0, out_valid}, 32'd0);
      chk($sformatf("vec%0d_idle_wr", i), {31'b0, wr_en_q}, 32'd0);
    end

    // Forward priority with a held instruction on rs=3
    @(negedge clk);
    idle();
    in_valid = 1; rs_addr = 3; rs_data = 32'h11; out_ready = 0;
    @(negedge clk);
    in_valid = 0;
    fwd_mem_en = 1; fwd_mem_addr = 3; fwd_mem_data = 32'hAA;
    fwd_wb_en = 1; fwd_wb_addr = 3; fwd_wb_data = 32'hBB;
    #1;
    chk("fwd_mem_prio", opa, FWD ? 32'hAA : 32'h11);
    chk("fwd_hold_in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    fwd_mem_en = 0;
    #1;
    chk("fwd_wb_only", opa, FWD ? 32'hBB : 32'h11);
    @(negedge clk);
    fwd_wb_en = 0;
    #1;
    chk("fwd_refresh_kept", opa, FWD ? 32'hBB : 32'h11);
    // Retire and capture rs=0 with both producers claiming register 0
    in_valid = 1; rs_addr = 0; rs_data = 32'h22; out_ready = 1;
    fwd_mem_en = 1; fwd_mem_addr = 0; fwd_wb_en = 1; fwd_wb_addr = 0;
    @(negedge clk);
    #1;
    chk("fwd_r0_opa", opa, 32'h22);
    // Immediate operand must ignore a matching rt producer
    rs_addr = 5; rs_data = 32'h1; rt_addr = 5; rt_data = 32'h2;
    use_imm = 1; imm16 = 16'h0042;
    fwd_mem_addr = 5; fwd_mem_data = 32'hAA; fwd_wb_en = 0;
    @(negedge clk);
    in_valid = 0;
    #1;
    chk("fwd_imm_opb", opb, 32'h42);
    chk("fwd_rs_mem", opa, FWD ? 32'hAA : 32'h1);

    // Stall refresh on rt=4
    @(negedge clk);
    idle();
    in_valid = 1; rt_addr = 4; rt_data = 32'h10; alu_op = ALU_SUB; out_ready = 0;
    @(negedge clk);
    in_valid = 0;
    fwd_wb_en = 1; fwd_wb_addr = 4; fwd_wb_data = 32'h55;
    #1;
    chk("stall_opb_fwd", opb, FWD ? 32'h55 : 32'h10);
    chk("stall_in_ready0", {31'b0, in_ready}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      fwd_wb_en = 0;
      #1;
      chk($sformatf("stall_opb_held%0d", k), opb, FWD ? 32'h55 : 32'h10);
      chk($sformatf("stall_in_ready%0d", k + 1), {31'b0, in_ready}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1;
    #1;
    chk("stall_retire_valid", {31'b0, out_valid}, 32'd1);
    chk("stall_retire_opb", opb, FWD ? 32'h55 : 32'h10);
    chk("stall_retire_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    #1;
    chk("stall_after_retire", {31'b0, out_valid}, 32'd0);

    // Flush on an incoming instruction, then on a held one
    idle();
    in_valid = 1; flush = 1; rs_data = 32'h99; alu_op = 4'd5;
    #1;
    chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    idle();
    #1;
    chk("flush_no_capture", {31'b0, out_valid}, 32'd0);
    in_valid = 1; alu_op = 4'd6; out_ready = 0;
    @(negedge clk);
    in_valid = 0; flush = 1;
    #1;
    chk("flush_held_before", {31'b0, out_valid}, 32'd1);
    @(negedge clk);
    flush = 0;
    #1;
    chk("flush_held_after", {31'b0, out_valid}, 32'd0);

    // Three back-to-back captures
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      idle();
      out_ready = 1;
      if (k < 3) begin
        in_valid = 1; alu_op = 4'(k + 1); rs_data = 32'(100 + k);
      end
      #1;
      if (k > 0) begin
        chk($sformatf("b2b%0d_valid", k), {31'b0, out_valid}, 32'd1);
        chk($sformatf("b2b%0d_op", k), {28'b0, op}, 32'(k));
        chk($sformatf("b2b%0d_opa", k), opa, 32'(99 + k));
      end
    end
    @(negedge clk);
    #1;
    chk("b2b_drain", {31'b0, out_valid}, 32'd0);

    // Asynchronous reset during a hold
    idle();
    in_valid = 1; alu_op = 4'd9; rs_data = 32'h77; wr_en = 1; rd_addr = 3; out_ready = 0;
    @(negedge clk);
    in_valid = 0;
    #1;
    chk("areset_pre_valid", {31'b0, out_valid}, 32'd1);
    #2;
    rst_n = 0;
    #1;
    chk("areset_valid", {31'b0, out_valid}, 32'd0);
    chk("areset_wr_en_q", {31'b0, wr_en_q}, 32'd0);
    chk("areset_opa", opa, 32'd0);
    chk("areset_op", {28'b0, op}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("areset_in_ready", {31'b0, in_ready}, 32'd1);

    // Randomized traffic against the model
    mv = 0; ma = 0; mb = 0; mop = 0; mrd = 0; mrs = 0; mrt = 0; mwr = 0; mimm = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rs_addr = 5'($urandom_range(0, 3));
      rt_addr = 5'($urandom_range(0, 3));
      rd_addr = 5'($urandom);
      rs_data = $urandom; rt_data = $urandom;
      wr_en = 1'($urandom); use_imm = 1'($urandom); imm_zext = 1'($urandom);
      imm16 = 16'($urandom);
      alu_op = ($urandom_range(0, 3) == 0) ? ALU_MVHI : 4'($urandom);
      fwd_mem_en = 1'($urandom); fwd_wb_en = 1'($urandom);
      fwd_mem_addr = 5'($urandom_range(0, 3)); fwd_wb_addr = 5'($urandom_range(0, 3));
      fwd_mem_data = $urandom; fwd_wb_data = $urandom;
      #1;
      eo_a = fwdv(mrs, ma);
      eo_b = mimm ? mb : fwdv(mrt, mb);
      chk("rnd_in_ready", {31'b0, in_ready}, {31'b0, !mv || out_ready});
      chk("rnd_valid", {31'b0, out_valid}, {31'b0, mv});
      chk("rnd_opa", opa, eo_a);
      chk("rnd_opb", opb, eo_b);
      chk("rnd_op", {28'b0, op}, {28'b0, mop});
      chk("rnd_rd", {27'b0, rd_addr_q}, {27'b0, mrd});
      chk("rnd_wr", {31'b0, wr_en_q}, {31'b0, mwr && mv});
      // Model next state from the stage's rules
      capm = in_valid && (!mv || out_ready) && !flush;
      ext = (imm_zext || alu_op == ALU_MVHI) ? 32'(imm16) : 32'(signed'(imm16));
      if (capm) begin
        ma = rs_data; mb = use_imm ? ext : rt_data;
        mop = alu_op; mrd = rd_addr; mrs = rs_addr; mrt = rt_addr;
        mwr = wr_en; mimm = use_imm;
      end else if (FWD && mv && !out_ready) begin
        ma = eo_a; mb = eo_b;
      end
      mv = flush ? 1'b0 : (capm ? 1'b1 : (mv && !out_ready));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
